mac_seq_ctrl: RTL and testbench
===============================

# mac_seq_ctrl

Sequencer for a bank of `LANES` MAC units performing a length-`DEPTH` dot product per lane (matrix-vector row block). It accepts a start pulse and clears the MACs. It streams `DEPTH` operand beats through a valid/ready handshake into the MAC `En`/`Ain`/`Bin` inputs. It then captures the accumulators and presents them on a valid/ready result port. It sits between the operand fetch logic (memory/FIFO) and the MAC array, which the parent instantiates.

## Interface
- `DATA_WIDTH`, 8, operand width; accumulator width is 3*DATA_WIDTH.
- `LANES`, 8, number of MAC lanes driven in parallel.
- `DEPTH`, 8, beats per dot product (≥1).

- `clk` input 1 single clock, rising edge.
- `rst` input 1 asynchronous, active-high reset.
- `start` input 1 begin a dot product; sampled only in IDLE.
- `busy` output 1 high in every state except IDLE.
- `done` output 1 one-cycle pulse on result handshake.
- `in_valid` input 1 operand beat valid.
- `in_ready` output 1 block accepts beat.
- `in_a` input LANES*DATA_WIDTH per-lane A operands, lane i at bits [i*DW +: DW].
- `in_b` input DATA_WIDTH B operand broadcast to all lanes.
- `mac_en` output 1 to MAC `En`.
- `mac_clr` output 1 to MAC `Clr`.
- `mac_a` output LANES*DATA_WIDTH to MAC `Ain` per lane.
- `mac_b` output DATA_WIDTH to MAC `Bin`.
- `mac_cout` input LANES*3*DATA_WIDTH MAC `Cout` per lane.
- `res_valid` output 1 result available.
- `res_ready` input 1 consumer accepts result.
- `res_data` output LANES*3*DATA_WIDTH registered results.

## Operation
- FSM states: IDLE, CLEAR, ACCUM, DRAIN, OUTPUT.
- IDLE: `in_ready`=0. `start`=1 → CLEAR. `start` in any other state is ignored; it is not queued.
- CLEAR: exactly one cycle. `mac_clr`=1 and beat counter `cnt`←0, then → ACCUM.
- ACCUM: `in_ready`=1. `mac_a`/`mac_b` are combinational pass-through of `in_a`/`in_b`. `mac_en` = `in_valid & in_ready`.
  - Each handshake increments `cnt`.
  - The handshake with `cnt`==DEPTH-1 → DRAIN.
  - `in_valid` low holds state with no MAC update.
- DRAIN: one cycle with `in_ready`=0. The MAC accumulator has already absorbed the last beat, so `res_data`←`mac_cout`. Then → OUTPUT.
- OUTPUT: `res_valid`=1 and `res_data` is held stable.
  - `res_ready`=1 → `done` pulse next cycle registered, → IDLE.
  - `res_valid` never drops without a handshake.
- `mac_en` and `mac_clr` are never high simultaneously. `mac_a`/`mac_b` are don't-care when `mac_en`=0.
- `cnt` width is $clog2(DEPTH)+1. It never wraps within a job.
- Arithmetic is unsigned. For DEPTH ≤ 2^DATA_WIDTH, no accumulator overflow is possible; no overflow detection.
- Reset, including mid-job: state IDLE, `cnt`=0, `res_data`=0. All outputs are 0: `busy`, `done`, `in_ready`, `mac_en`, `mac_clr`, `res_valid`. The partial job is discarded, and the next job's CLEAR wipes MAC state.

## Timing
- Cycle 0: `start` sampled high in IDLE. Cycle 1: CLEAR. Cycles 2..DEPTH+1: ACCUM, with zero stalls.
- Cycle DEPTH+2: DRAIN. Cycle DEPTH+3: `res_valid`=1.
- Minimum start-to-result latency is DEPTH+3 cycles. Each `in_valid` stall cycle adds one.
- `done` is asserted the cycle after the `res_valid & res_ready` edge, coincident with IDLE. `start` in that same cycle is accepted.
- Minimum job period is DEPTH+4 cycles.

## Configuration
- `MAC_SEQ_STALL_CNT_EN` defined adds output `stall_cnt` [15:0]:
  - Counts ACCUM cycles with `in_valid`=0 plus OUTPUT cycles with `res_ready`=0.
  - Cleared in CLEAR, held otherwise, and saturates at 16'hFFFF.
  - Reset value is 0.
- Undefined: no port and no counter logic; all other behaviour is identical.

## Structure
- Package `mac_seq_pkg`: state enum `mac_seq_state_t` (IDLE, CLEAR, ACCUM, DRAIN, OUTPUT) and the accumulator width function ACC_W(dw)=3*dw.
- Single module with no sub-module. The MAC lanes are instantiated by the parent and wired to the `mac_*` ports.

## Test plan
- LANES=2, DEPTH=4, DW=8, lane0 A=1,2,3,4, lane1 A=5,6,7,8, B=1,1,1,1, no stalls → `res_data` lane0=10, lane1=26. `res_valid` is first high 7 cycles after `start`.
- Max values: A=255, B=255, DEPTH=8 → every lane=520200 (0x07F008). No truncation.
- `in_valid` low for 3 cycles mid-ACCUM → same result. `mac_en` is low during the stall, and `res_valid` arrives 3 cycles later. With `MAC_SEQ_STALL_CNT_EN`, `stall_cnt`=3.
- `res_ready` low for 5 cycles → `res_data` stable, `done` absent, `start` ignored. On release, `done` pulses for one cycle, then a back-to-back `start` is accepted.
- `rst` asserted after 2 beats → all outputs 0 immediately. The next job gives a correct result with no residue from the aborted job.
- `start` held high continuously → jobs run back-to-back. `mac_clr` pulses once per job and never overlaps `mac_en`.

Source files
------------

// File: rtl/mac_seq_ctrl_pkg.sv
// Shared types for the MAC dot-product sequencer: FSM state encoding and accumulator width helper.
package mac_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    ACCUM  = 3'd2,
    DRAIN  = 3'd3,
    OUTPUT = 3'd4
  } mac_seq_state_t;

  // Three operand widths hold DEPTH <= 2^dw products of two dw-bit values without overflow.
  function automatic int ACC_W(input int dw);
    return 3 * dw;
  endfunction

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Control, operand stream, MAC array and result port bundle for mac_seq_ctrl.
// Carries stall_cnt only when MAC_SEQ_STALL_CNT_EN is defined.
interface mac_seq_ctrl_if
  import mac_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 8
);
  localparam int AW = ACC_W(DATA_WIDTH);

  logic                          start;
  logic                          busy;
  logic                          done;
  logic                          in_valid;
  logic                          in_ready;
  logic [LANES*DATA_WIDTH-1:0]   in_a;
  logic [DATA_WIDTH-1:0]         in_b;
  logic                          mac_en;
  logic                          mac_clr;
  logic [LANES*DATA_WIDTH-1:0]   mac_a;
  logic [DATA_WIDTH-1:0]         mac_b;
  logic [LANES*AW-1:0]           mac_cout;
  logic                          res_valid;
  logic                          res_ready;
  logic [LANES*AW-1:0]           res_data;
`ifdef MAC_SEQ_STALL_CNT_EN
  logic [15:0]                   stall_cnt;
`endif

`ifdef MAC_SEQ_STALL_CNT_EN
  modport slave (
    input  start, in_valid, in_a, in_b, mac_cout, res_ready,
    output busy, done, in_ready, mac_en, mac_clr, mac_a, mac_b, res_valid, res_data, stall_cnt
  );
  modport master (
    output start, in_valid, in_a, in_b, mac_cout, res_ready,
    input  busy, done, in_ready, mac_en, mac_clr, mac_a, mac_b, res_valid, res_data, stall_cnt
  );
`else
  modport slave (
    input  start, in_valid, in_a, in_b, mac_cout, res_ready,
    output busy, done, in_ready, mac_en, mac_clr, mac_a, mac_b, res_valid, res_data
  );
  modport master (
    output start, in_valid, in_a, in_b, mac_cout, res_ready,
    input  busy, done, in_ready, mac_en, mac_clr, mac_a, mac_b, res_valid, res_data
  );
`endif

endinterface

// File: rtl/mac_seq_ctrl.sv
// Sequences one DEPTH-beat dot product per job across LANES external MAC units.
// Define MAC_SEQ_STALL_CNT_EN to add the saturating stall_cnt output.
module mac_seq_ctrl
  import mac_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 8,
  parameter int DEPTH      = 8
) (
  input  logic          clk,
  input  logic          rst,
  mac_seq_ctrl_if.slave bus
);

  localparam int AW = ACC_W(DATA_WIDTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(DEPTH - 1);

  mac_seq_state_t state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           done_q, done_d;
  logic           in_fire;

  assign in_fire = bus.in_valid && (state_q == ACCUM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) state_d = CLEAR;
      end
      CLEAR: begin
        cnt_d   = '0;
        state_d = ACCUM;
      end
      ACCUM: begin
        if (in_fire) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_BEAT) state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = OUTPUT;
      end
      OUTPUT: begin
        if (bus.res_ready) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.mac_en    = in_fire;
  assign bus.mac_clr   = (state_q == CLEAR);
  assign bus.mac_a     = bus.in_a;
  assign bus.mac_b     = bus.in_b;
  assign bus.res_valid = (state_q == OUTPUT);

  // The last beat was absorbed on the edge entering DRAIN, so Cout is final here.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [AW-1:0] res_lane_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        res_lane_q <= '0;
      end else if (state_q == DRAIN) begin
        res_lane_q <= bus.mac_cout[gi*AW +: AW];
      end
    end

    assign bus.res_data[gi*AW +: AW] = res_lane_q;
  end

`ifdef MAC_SEQ_STALL_CNT_EN
  logic [15:0] stall_cnt_q;
  logic        stall_cyc;

  assign stall_cyc = ((state_q == ACCUM)  && !bus.in_valid) ||
                     ((state_q == OUTPUT) && !bus.res_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (state_q == CLEAR) begin
      stall_cnt_q <= '0;
    end else if (stall_cyc && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Randomized and directed checks of mac_seq_ctrl against a job-level dot-product model.
module tb_mac_seq_ctrl;

  localparam int DW   = 8;
  localparam int LN   = 2;
  localparam int DP   = 4;
  localparam int AW   = 3 * DW;
  localparam int AWID = LN * DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mac_seq_ctrl_if #(.DATA_WIDTH(DW), .LANES(LN)) bus ();

  mac_seq_ctrl #(.DATA_WIDTH(DW), .LANES(LN), .DEPTH(DP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Stand-in for the parent's MAC array: clear wins, else accumulate on enable.
  logic [AW-1:0] acc [LN];
  always @(posedge clk) begin
    for (int l = 0; l < LN; l++) begin
      if (bus.mac_clr)
        acc[l] <= '0;
      else if (bus.mac_en)
        acc[l] <= acc[l] + AW'(bus.mac_a[l*DW +: DW]) * AW'(bus.mac_b);
    end
  end
  always_comb begin
    bus.mac_cout = '0;
    for (int l = 0; l < LN; l++) bus.mac_cout[l*AW +: AW] = acc[l];
  end

  int n_checks = 0;
  int n_errors = 0;
  int jobs_started = 0;
  int clr_pulses = 0;
  int overlap = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.mac_clr) clr_pulses++;
    if (bus.mac_clr && bus.mac_en) overlap++;
  end

  logic [DW-1:0] job_a [DP][LN];
  logic [DW-1:0] job_b [DP];

  task automatic fill_rand();
    for (int d = 0; d < DP; d++) begin
      job_b[d] = DW'($urandom());
      for (int l = 0; l < LN; l++) job_a[d][l] = DW'($urandom());
    end
  endtask

  task automatic run_job(input int stall_at, input int stall_len, input int hold,
                         input bit prestarted, input bit keep_start);
    logic [LN*AW-1:0] exp_res;
    int unsigned s;
    int beat, sc;
    bit v;
    for (int l = 0; l < LN; l++) begin
      s = 0;
      for (int d = 0; d < DP; d++) s += job_a[d][l] * job_b[d];
      exp_res[l*AW +: AW] = AW'(s);
    end
    if (!prestarted) begin
      @(posedge clk); #1;
      bus.start = 1'b1;
      @(negedge clk);
      check_val("idle_busy", bus.busy, 1'b0);
    end
    @(posedge clk); #1;
    bus.start = keep_start;
    jobs_started++;
    @(negedge clk);
    check_val("clear_clr", bus.mac_clr, 1'b1);
    check_val("clear_busy", bus.busy, 1'b1);
    check_val("clear_rdy", bus.in_ready, 1'b0);
    beat = 0;
    sc = 0;
    while (beat < DP) begin
      @(posedge clk); #1;
      if (beat == stall_at && sc < stall_len) begin
        v = 1'b0;
        sc++;
        bus.in_a = AWID'($urandom());
        bus.in_b = DW'($urandom());
      end else begin
        v = 1'b1;
        for (int l = 0; l < LN; l++) bus.in_a[l*DW +: DW] = job_a[beat][l];
        bus.in_b = job_b[beat];
      end
      bus.in_valid = v;
      @(negedge clk);
      check_val("accum_rdy", bus.in_ready, 1'b1);
      check_val("accum_en", bus.mac_en, v);
      if (v) beat++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_val("drain_rdy", bus.in_ready, 1'b0);
    check_val("drain_rv", bus.res_valid, 1'b0);
    check_val("drain_busy", bus.busy, 1'b1);
    @(posedge clk); #1;
    bus.res_ready = (hold == 0);
    if (!keep_start) bus.start = (hold > 0);
    @(negedge clk);
    check_val("out_rv", bus.res_valid, 1'b1);
    for (int l = 0; l < LN; l++)
      check_val($sformatf("res_lane%0d", l), bus.res_data[l*AW +: AW], exp_res[l*AW +: AW]);
    for (int k = 1; k <= hold; k++) begin
      @(posedge clk); #1;
      bus.res_ready = (k == hold);
      @(negedge clk);
      check_val("hold_rv", bus.res_valid, 1'b1);
      check_val("hold_done", bus.done, 1'b0);
      check_val("hold_data", bus.res_data, exp_res);
    end
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    bus.start = keep_start;
    @(negedge clk);
    check_val("done_pulse", bus.done, 1'b1);
    check_val("done_busy", bus.busy, 1'b0);
    check_val("done_rv", bus.res_valid, 1'b0);
`ifdef MAC_SEQ_STALL_CNT_EN
    check_val("stall_cnt", bus.stall_cnt, 64'(stall_len + hold));
`endif
    $display("job %0d: stall_at=%0d stall_len=%0d hold=%0d lane0=%0d lane1=%0d",
             jobs_started, stall_at, stall_len, hold, exp_res[0 +: AW], exp_res[AW +: AW]);
    if (!keep_start) begin
      @(posedge clk); #1;
      @(negedge clk);
      check_val("done_once", bus.done, 1'b0);
      check_val("no_queue", bus.busy, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.res_ready = 1'b0;
    for (int l = 0; l < LN; l++) acc[l] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_busy", bus.busy, 1'b0);
    check_val("rst_rv", bus.res_valid, 1'b0);
    check_val("rst_data", bus.res_data, '0);
    check_val("rst_clr", bus.mac_clr, 1'b0);
    rst = 1'b0;

    // Directed: ramp operands with unit B.
    for (int d = 0; d < DP; d++) begin
      job_a[d][0] = DW'(d + 1);
      job_a[d][1] = DW'(d + 5);
      job_b[d]    = 8'd1;
    end
    run_job(-1, 0, 0, 1'b0, 1'b0);

    // Max operands: no truncation of the full-width sum.
    for (int d = 0; d < DP; d++) begin
      job_b[d] = 8'hFF;
      for (int l = 0; l < LN; l++) job_a[d][l] = 8'hFF;
    end
    run_job(-1, 0, 0, 1'b0, 1'b0);

    fill_rand();
    run_job(2, 3, 0, 1'b0, 1'b0);
    fill_rand();
    run_job(-1, 0, 5, 1'b0, 1'b0);

    // Reset after two accepted beats.
    fill_rand();
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    jobs_started++;
    for (int b = 0; b < 2; b++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      for (int l = 0; l < LN; l++) bus.in_a[l*DW +: DW] = job_a[b][l];
      bus.in_b = job_b[b];
    end
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_val("abort_busy", bus.busy, 1'b0);
    check_val("abort_en", bus.mac_en, 1'b0);
    check_val("abort_rdy", bus.in_ready, 1'b0);
    check_val("abort_done", bus.done, 1'b0);
    check_val("abort_rv", bus.res_valid, 1'b0);
    check_val("abort_data", bus.res_data, '0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    $display("job %0d: aborted by reset after 2 beats", jobs_started);
    fill_rand();
    run_job(-1, 0, 0, 1'b0, 1'b0);

    // Start held high: jobs chain back to back.
    fill_rand();
    run_job(-1, 0, 0, 1'b0, 1'b1);
    fill_rand();
    run_job(1, 1, 2, 1'b1, 1'b1);
    fill_rand();
    run_job(-1, 0, 0, 1'b1, 1'b0);

    for (int j = 0; j < 20; j++) begin
      fill_rand();
      run_job(int'($urandom_range(0, DP - 1)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), 1'b0, 1'b0);
    end

    check_val("clr_per_job", 64'(clr_pulses), 64'(jobs_started));
    check_val("clr_en_overlap", 64'(overlap), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
